// File: rtl/store_commit_queue.sv
// store_commit_queue: in-order store queue tracking alloc/exec/commit per entry
// and presenting the oldest committed store to the memory arbiter.
module store_commit_queue #(
    parameter int DEPTH  = 8,
    parameter int ROB_W  = 5,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc_valid,
    input  logic [ROB_W-1:0]           alloc_rob_addr,
    output logic                       alloc_ready,
    output logic [$clog2(DEPTH)-1:0]   alloc_idx,
    input  logic                       exec_valid,
    input  logic [$clog2(DEPTH)-1:0]   exec_idx,
    input  logic [ADDR_W-1:0]          exec_addr,
    input  logic [DATA_W-1:0]          exec_data,
    input  logic                       commit_valid,
    input  logic [ROB_W-1:0]           commit_rob_addr,
    input  logic                       flush,
    input  logic                       pop,
    output logic                       ready,
    output logic [ROB_W-1:0]           rob_addr,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       commit_err
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {FREE, ALLOC, EXEC, CMTD} state_t;

    state_t              st     [DEPTH];
    logic [ROB_W-1:0]    rob    [DEPTH];
    logic [ADDR_W-1:0]   addr_q [DEPTH];
    logic [DATA_W-1:0]   data_q [DEPTH];
    logic [IW-1:0]       head, tail, cmt;
    logic [IW:0]         ucnt;
    logic                commit_hit, do_alloc, do_exec, do_commit, do_pop;

    assign alloc_ready = count != (IW+1)'(DEPTH);
    assign alloc_idx   = tail;
    assign ready       = st[head] == CMTD;
    assign rob_addr    = rob[head];
    assign mem_addr    = addr_q[head];
    assign mem_data    = data_q[head];

    // cmt always points at the oldest uncommitted entry, so a FREE or COMMITTED slot there means nothing to commit
    assign commit_hit = st[cmt] == EXEC && rob[cmt] == commit_rob_addr;
    assign do_commit  = commit_valid && commit_hit;
    assign do_alloc   = alloc_valid && alloc_ready && !flush;
    assign do_exec    = exec_valid && st[exec_idx] == ALLOC && !flush;
    assign do_pop     = pop && ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                st[i]     <= FREE;
                rob[i]    <= '0;
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            head       <= '0;
            tail       <= '0;
            cmt        <= '0;
            ucnt       <= '0;
            count      <= '0;
            commit_err <= 1'b0;
        end else begin
            if (do_exec) begin
                st[exec_idx]     <= EXEC;
                addr_q[exec_idx] <= exec_addr;
                data_q[exec_idx] <= exec_data;
            end
            if (do_alloc) begin
                st[tail]  <= ALLOC;
                rob[tail] <= alloc_rob_addr;
                tail      <= tail + 1'b1;
            end
            if (do_commit) begin
                st[cmt] <= CMTD;
                cmt     <= cmt + 1'b1;
            end
            if (commit_valid && !commit_hit)
                commit_err <= 1'b1;
            if (do_pop) begin
                st[head] <= FREE;
                head     <= head + 1'b1;
            end
            // Flush keeps the entry committing this cycle; everything younger is squashed
            if (flush) begin
                for (int i = 0; i < DEPTH; i++)
                    if ((st[i] == ALLOC || st[i] == EXEC) && !(do_commit && IW'(i) == cmt))
                        st[i] <= FREE;
                tail  <= cmt + IW'(do_commit);
                ucnt  <= '0;
                count <= count - ucnt + (IW+1)'(do_commit) - (IW+1)'(do_pop);
            end else begin
                ucnt  <= ucnt + (IW+1)'(do_alloc) - (IW+1)'(do_commit);
                count <= count + (IW+1)'(do_alloc) - (IW+1)'(do_pop);
            end
        end
    end
endmodule

// File: tb/tb_store_commit_queue.sv
// tb_store_commit_queue: directed scenarios plus randomized traffic checked
// against an in-order list model of the store queue.
module tb_store_commit_queue;
    logic        clk = 0, rst = 0;
    logic        alloc_valid = 0, exec_valid = 0, commit_valid = 0, flush = 0, pop = 0;
    logic [4:0]  alloc_rob_addr = 0, commit_rob_addr = 0;
    logic [2:0]  exec_idx = 0;
    logic [15:0] exec_addr = 0, exec_data = 0;
    logic        alloc_ready, ready, commit_err;
    logic [2:0]  alloc_idx;
    logic [4:0]  rob_addr;
    logic [15:0] mem_addr, mem_data;
    logic [3:0]  count;

    int n_checks = 0, n_fail = 0;

    store_commit_queue dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_rob_addr(alloc_rob_addr),
        .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .exec_valid(exec_valid), .exec_idx(exec_idx),
        .exec_addr(exec_addr), .exec_data(exec_data),
        .commit_valid(commit_valid), .commit_rob_addr(commit_rob_addr),
        .flush(flush), .pop(pop),
        .ready(ready), .rob_addr(rob_addr), .mem_addr(mem_addr), .mem_data(mem_data),
        .count(count), .commit_err(commit_err)
    );

    always #5 clk = ~clk;

    // Reference: program-order list of live stores, each remembering its slot
    typedef struct {
        int         slot;
        logic [4:0] rob;
        logic [15:0] a;
        logic [15:0] d;
        bit         ex;
        bit         cm;
    } ent_t;
    ent_t q[$];
    int   mhead = 0;
    bit   merr = 0;

    function automatic int m_tail();
        return (mhead + q.size()) % 8;
    endfunction

    function automatic bit m_ready();
        return q.size() > 0 && q[0].cm;
    endfunction

    function automatic int m_oldest_unc();
        for (int i = 0; i < q.size(); i++)
            if (!q[i].cm) return i;
        return -1;
    endfunction

    task automatic idle();
        alloc_valid = 0; exec_valid = 0; commit_valid = 0; flush = 0; pop = 0;
    endtask

    task automatic tick();
        int   sz = q.size();
        int   ptail = m_tail();
        int   k = m_oldest_unc();
        bit   cok = 0, pok, aok;
        ent_t n;
        ent_t keep[$];
        if (commit_valid) begin
            cok = k >= 0 && q[k].ex && q[k].rob == commit_rob_addr;
            if (!cok) merr = 1;
        end
        pok = pop && sz > 0 && q[0].cm;
        aok = alloc_valid && !flush && sz < 8;
        if (exec_valid && !flush)
            for (int i = 0; i < sz; i++)
                if (q[i].slot == int'(exec_idx) && !q[i].ex) begin
                    q[i].ex = 1; q[i].a = exec_addr; q[i].d = exec_data;
                end
        if (cok) q[k].cm = 1;
        if (flush) begin
            foreach (q[i]) if (q[i].cm) keep.push_back(q[i]);
            q = keep;
        end
        if (aok) begin
            n.slot = ptail; n.rob = alloc_rob_addr; n.a = 0; n.d = 0; n.ex = 0; n.cm = 0;
            q.push_back(n);
        end
        if (pok) begin
            void'(q.pop_front());
            mhead = (mhead + 1) % 8;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        q.delete(); mhead = 0; merr = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (ready !== 1'b0 || alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_flags: ready=%b alloc_ready=%b expected 0/1", ready, alloc_ready); end
        n_checks++; if (rob_addr !== 5'd0 || mem_addr !== 16'd0 || mem_data !== 16'd0 || commit_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: rob=%0h addr=%0h data=%0h err=%b expected all 0", rob_addr, mem_addr, mem_data, commit_err); end
        // three entries, first one committed, then reset between clock edges
        alloc_valid = 1;
        for (int i = 0; i < 3; i++) begin alloc_rob_addr = 5'(20 + i); tick(); end
        idle();
        exec_valid = 1; exec_idx = 0; exec_addr = 16'h1234; exec_data = 16'h5678; tick(); idle();
        commit_valid = 1; commit_rob_addr = 5'd20; tick(); idle();
        n_checks++; if (count !== 4'd3 || ready !== 1'b1) begin n_fail++; $display("FAIL reset_pre: count=%0d ready=%b expected 3/1", count, ready); end
        #3 rst = 1;
        #1;
        n_checks++; if (count !== 4'd0 || ready !== 1'b0 || alloc_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_async: count=%0d ready=%b alloc_ready=%b expected 0/0/1", count, ready, alloc_ready); end
        q.delete(); mhead = 0; merr = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        n_checks++; if (alloc_idx !== 3'd0 || commit_err !== 1'b0) begin n_fail++; $display("FAIL reset_ptr: alloc_idx=%0d err=%b expected 0/0", alloc_idx, commit_err); end
    endtask

    task automatic test_fill();
        do_reset();
        alloc_valid = 1;
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (alloc_idx !== 3'(i) || alloc_ready !== 1'b1) begin
                n_fail++; $display("FAIL fill_idx%0d: alloc_idx=%0d alloc_ready=%b expected %0d/1", i, alloc_idx, alloc_ready, i); end
            alloc_rob_addr = 5'(i);
            tick();
        end
        n_checks++; if (count !== 4'd8 || alloc_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full: count=%0d alloc_ready=%b expected 8/0", count, alloc_ready); end
        alloc_rob_addr = 5'd9; pop = 1; tick(); idle();
        n_checks++; if (count !== 4'd8 || alloc_ready !== 1'b0 || ready !== 1'b0) begin
            n_fail++; $display("FAIL fill_overflow: count=%0d alloc_ready=%b ready=%b expected 8/0/0", count, alloc_ready, ready); end
    endtask

    task automatic test_order();
        do_reset();
        alloc_valid = 1; alloc_rob_addr = 5'd3; tick(); alloc_rob_addr = 5'd4; tick(); idle();
        exec_valid = 1; exec_idx = 0; exec_addr = 16'h1000; exec_data = 16'hAAAA; tick();
        exec_idx = 1; exec_addr = 16'h1002; exec_data = 16'hBBBB; tick(); idle();
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL order_precommit: ready=%b expected 0", ready); end
        commit_valid = 1; commit_rob_addr = 5'd3; tick(); idle();
        n_checks++; if (ready !== 1'b1 || rob_addr !== 5'd3 || mem_addr !== 16'h1000 || mem_data !== 16'hAAAA) begin
            n_fail++; $display("FAIL order_head3: ready=%b rob=%0d addr=%h data=%h expected 1/3/1000/aaaa", ready, rob_addr, mem_addr, mem_data); end
        pop = 1; tick(); idle();
        n_checks++; if (ready !== 1'b0 || rob_addr !== 5'd4 || count !== 4'd1) begin
            n_fail++; $display("FAIL order_pop: ready=%b rob=%0d count=%0d expected 0/4/1", ready, rob_addr, count); end
        pop = 1; tick(); idle();
        n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL order_pop_ignored: count=%0d expected 1", count); end
        commit_valid = 1; commit_rob_addr = 5'd4; tick(); idle();
        n_checks++; if (ready !== 1'b1 || rob_addr !== 5'd4 || mem_data !== 16'hBBBB || commit_err !== 1'b0) begin
            n_fail++; $display("FAIL order_head4: ready=%b rob=%0d data=%h err=%b expected 1/4/bbbb/0", ready, rob_addr, mem_data, commit_err); end
        pop = 1; tick(); idle();
        n_checks++; if (count !== 4'd0 || ready !== 1'b0) begin n_fail++; $display("FAIL order_empty: count=%0d ready=%b expected 0/0", count, ready); end
    endtask

    task automatic test_flush();
        do_reset();
        alloc_valid = 1;
        for (int i = 0; i < 3; i++) begin alloc_rob_addr = 5'(10 + i); tick(); end
        idle(); exec_valid = 1;
        for (int i = 0; i < 3; i++) begin exec_idx = 3'(i); exec_addr = 16'(16'h200 + i); exec_data = 16'(i); tick(); end
        idle();
        commit_valid = 1; commit_rob_addr = 5'd10; tick(); idle();
        flush = 1; alloc_valid = 1; alloc_rob_addr = 5'd30; tick(); idle();
        n_checks++; if (count !== 4'd1 || alloc_idx !== 3'd1) begin n_fail++; $display("FAIL flush_state: count=%0d tail=%0d expected 1/1", count, alloc_idx); end
        n_checks++; if (ready !== 1'b1 || rob_addr !== 5'd10 || mem_addr !== 16'h200) begin
            n_fail++; $display("FAIL flush_head: ready=%b rob=%0d addr=%h expected 1/10/200", ready, rob_addr, mem_addr); end
        commit_valid = 1; commit_rob_addr = 5'd11; tick(); idle();
        n_checks++; if (commit_err !== 1'b1) begin n_fail++; $display("FAIL flush_squashed: err=%b expected 1", commit_err); end
        pop = 1; tick(); idle();
        n_checks++; if (count !== 4'd0 || ready !== 1'b0) begin n_fail++; $display("FAIL flush_drain: count=%0d ready=%b expected 0/0", count, ready); end
    endtask

    task automatic test_error();
        do_reset();
        alloc_valid = 1; alloc_rob_addr = 5'd6; tick(); idle();
        commit_valid = 1; commit_rob_addr = 5'd6; tick(); idle();
        n_checks++; if (commit_err !== 1'b1 || ready !== 1'b0) begin n_fail++; $display("FAIL err_before_exec: err=%b ready=%b expected 1/0", commit_err, ready); end
        do_reset();
        alloc_valid = 1; alloc_rob_addr = 5'd6; tick(); idle();
        exec_valid = 1; exec_idx = 0; exec_addr = 16'h66; exec_data = 16'h77; tick(); idle();
        commit_valid = 1; commit_rob_addr = 5'd5; tick(); idle();
        n_checks++; if (commit_err !== 1'b1 || ready !== 1'b0 || count !== 4'd1) begin
            n_fail++; $display("FAIL err_mismatch: err=%b ready=%b count=%0d expected 1/0/1", commit_err, ready, count); end
        commit_valid = 1; commit_rob_addr = 5'd6; tick(); idle();
        n_checks++; if (commit_err !== 1'b1 || ready !== 1'b1 || rob_addr !== 5'd6) begin
            n_fail++; $display("FAIL err_sticky: err=%b ready=%b rob=%0d expected 1/1/6", commit_err, ready, rob_addr); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            n_checks++; if (alloc_idx !== 3'(i % 8)) begin n_fail++; $display("FAIL wrap_idx%0d: got %0d expected %0d", i, alloc_idx, i % 8); end
            alloc_valid = 1; alloc_rob_addr = 5'(i); tick(); idle();
            exec_valid = 1; exec_idx = 3'(i % 8); exec_addr = 16'(i * 3); exec_data = 16'(i * 5); tick(); idle();
            commit_valid = 1; commit_rob_addr = 5'(i); tick(); idle();
            n_checks++; if (ready !== 1'b1 || rob_addr !== 5'(i) || mem_data !== 16'(i * 5) || commit_err !== 1'b0) begin
                n_fail++; $display("FAIL wrap_head%0d: ready=%b rob=%0d data=%0h err=%b", i, ready, rob_addr, mem_data, commit_err); end
            pop = 1; tick(); idle();
        end
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL wrap_end: count=%0d expected 0", count); end
    endtask

    task automatic test_random();
        int alloc_slots[$];
        int k;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            alloc_valid = $urandom_range(0, 2) != 0;
            alloc_rob_addr = 5'($urandom);
            alloc_slots.delete();
            foreach (q[i]) if (!q[i].ex) alloc_slots.push_back(q[i].slot);
            exec_valid = $urandom_range(0, 1);
            exec_idx = (alloc_slots.size() > 0 && $urandom_range(0, 9) < 8)
                       ? 3'(alloc_slots[$urandom_range(0, alloc_slots.size() - 1)]) : 3'($urandom);
            exec_addr = 16'($urandom);
            exec_data = 16'($urandom);
            k = m_oldest_unc();
            commit_valid = $urandom_range(0, 2) == 0;
            commit_rob_addr = (k >= 0 && $urandom_range(0, 19) != 0) ? q[k].rob : 5'($urandom);
            pop = $urandom_range(0, 1);
            flush = $urandom_range(0, 29) == 0;
            tick();
            n_checks++; if (count !== 4'(q.size()) || alloc_ready !== (q.size() < 8) || alloc_idx !== 3'(m_tail())) begin
                n_fail++; $display("FAIL rand_occ@%0d: count=%0d alloc_ready=%b tail=%0d expected %0d/%b/%0d",
                                   c, count, alloc_ready, alloc_idx, q.size(), q.size() < 8, m_tail()); end
            n_checks++; if (ready !== m_ready() || commit_err !== merr) begin
                n_fail++; $display("FAIL rand_flags@%0d: ready=%b err=%b expected %b/%b", c, ready, commit_err, m_ready(), merr); end
            if (m_ready()) begin
                n_checks++; if (rob_addr !== q[0].rob || mem_addr !== q[0].a || mem_data !== q[0].d) begin
                    n_fail++; $display("FAIL rand_head@%0d: rob=%0d addr=%h data=%h expected %0d/%h/%h",
                                       c, rob_addr, mem_addr, mem_data, q[0].rob, q[0].a, q[0].d); end
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_order();
        test_flush();
        test_error();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
